pol_sched: RTL and testbench
============================

POL_SCHED -- requirements
Module: pol_sched

Interface
REQ-001 Parameter NUM_PCC, default 4, number of max-pooling cores served (power of two, 2..8).
REQ-002 Parameter IDX_WIDTH, default 16, point-index and feature-address width.
REQ-003 Parameter K_WIDTH, default 6, width of neighbours-per-point count.
REQ-004 Parameter TAG_DEPTH, default 8, outstanding feature-read tag FIFO depth (power of two).
REQ-005 Ports, as name, direction, width, meaning:
- clk  in  1  sole clock; all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- CfgVld/CfgRdy  in/out  1/1  job handshake.
- CfgNp  in  IDX_WIDTH  points in job.
- CfgK  in  K_WIDTH  neighbours per point.
- IdxVld/IdxRdy  in/out  1/1  neighbour-index stream.
- IdxDat  in  IDX_WIDTH  neighbour-index payload.
- FeaRdVld/FeaRdRdy  out/in  1/1  feature-read request handshake.
- FeaRdAddr  out  IDX_WIDTH  feature-read address.
- FeaDatVld/FeaDatRdy  in/out  1/1  returned feature beat, in request order, arbitrary latency.
- PccInVld  out  NUM_PCC  per-core DatInVld.
- PccInLast  out  NUM_PCC  per-core DatInLast.
- PccInRdy  in  NUM_PCC  per-core DatInRdy.
- PccSel  out  clog2(NUM_PCC)  data-mux select.
- PccOutVld  in  NUM_PCC  per-core DatOutVld.
- PccOutRdy  out  NUM_PCC  per-core DatOutRdy.
- OutVld/OutRdy  out/in  1/1  pooled-result handshake; result beats leave strictly in point order.
- OutSel  out  clog2(NUM_PCC)  result-mux select.
- OutPnt  out  IDX_WIDTH  point number of current result.
- PccRst  out  1  clear pulse to all cores.
- Done  out  1  one-cycle job-complete pulse.

Function
REQ-006 FSM states: IDLE, ISSUE, DRAIN, FIN.
REQ-007 IDLE: CfgRdy=1; on CfgVld latch CfgNp/CfgK, pulse PccRst one cycle, go ISSUE; if CfgNp==0 or CfgK==0 go FIN instead, no requests.
REQ-008 Point p is owned by core p mod NUM_PCC; point counter and neighbour counter kept.
REQ-009 ISSUE: IdxRdy = FeaRdRdy & tag FIFO not full & owner core free; FeaRdVld = IdxVld & same conditions; FeaRdAddr = IdxDat combinationally (zero latency).
REQ-010 Each accepted request pushes tag {core, last}; last=1 on neighbour CfgK-1; owner core marked busy on first neighbour.
REQ-011 After last neighbour of point CfgNp-1 accepted, go DRAIN.
REQ-012 Return path: FeaDatRdy = FIFO not empty & PccInRdy[head.core]; PccInVld[head.core] = FeaDatVld & FIFO not empty; PccInLast = head.last; PccSel = head.core; pop on FeaDatVld & FeaDatRdy.
REQ-013 Output: out pointer o starts 0; OutSel = o mod NUM_PCC; OutVld = PccOutVld[OutSel] & core busy & its last beat delivered; PccOutRdy[OutSel] = OutRdy under same condition; on transfer clear busy, increment o.
REQ-014 DRAIN: go FIN when o == CfgNp and FIFO empty; FIN: Done=1 for one cycle, then IDLE.
REQ-015 Simultaneous push and pop on a full FIFO is not allowed (push blocked by full); on empty, pop blocked.
REQ-016 Simultaneous busy-set and busy-clear on one core cannot occur; the issue side waits for the clear.
REQ-017 Counters never wrap within a job; CfgNp up to 2^IDX_WIDTH-1.

Reset
REQ-018 Rst (any state, mid-job included) forces next cycle: IDLE, counters 0, FIFO empty, busy cleared.
REQ-019 Reset values: CfgRdy=1, Done=0, OutVld=0, FeaRdVld=0, PccInVld=0, PccOutRdy=0, IdxRdy=0, FeaDatRdy=0.
REQ-020 During Rst, PccRst=1.

Configuration
REQ-021 Macro POL_SCHED_PERF_EN defined: 32-bit output PerfStall counts ISSUE cycles with IdxVld=1 & IdxRdy=0; PerfStall clears on Rst and on job accept, saturates at max.
REQ-022 POL_SCHED_PERF_EN undefined: port PerfStall and its logic are absent; all other behaviour identical.

Verification
REQ-023 CfgNp=3, CfgK=2, all ready=1, 1-cycle fixed read latency -> 6 requests; PccInLast on beats 2/4/6 to cores 0/1/2; OutPnt 0,1,2; one Done.
REQ-024 CfgNp=0 -> no FeaRdVld; Done 2 cycles after config accept.
REQ-025 NUM_PCC=4, CfgNp=6, OutRdy held 0 -> issue stalls at point 4 (core 0 busy); release OutRdy -> completes in order 0..5.
REQ-026 FeaDatVld held 0, CfgK=16 -> exactly TAG_DEPTH=8 requests issued, then IdxRdy=0.
REQ-027 Rst asserted in DRAIN with 3 tags pending -> next cycle CfgRdy=1, FIFO empty, no Done; new job runs clean.
REQ-028 With POL_SCHED_PERF_EN, FeaRdRdy=0 for 5 cycles while IdxVld=1 -> PerfStall=5.

Source files
------------

// File: rtl/pol_sched.sv
// pol_sched: schedules neighbour feature reads onto NUM_PCC max-pooling cores
// and returns pooled results strictly in point order.
// Optional build macro: POL_SCHED_PERF_EN adds the 32-bit PerfStall port.
//
// state | meaning
// IDLE  | waiting for a job, CfgRdy high
// ISSUE | issuing feature reads, one point in flight per owner core
// DRAIN | all reads issued, waiting for returns and pooled results
// FIN   | job finished, Done pulses on the following cycle
module pol_sched #(
   parameter int NUM_PCC   = 4,
   parameter int IDX_WIDTH = 16,
   parameter int K_WIDTH   = 6,
   parameter int TAG_DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       Rst,
   input  logic                       CfgVld,
   output logic                       CfgRdy,
   input  logic [IDX_WIDTH-1:0]       CfgNp,
   input  logic [K_WIDTH-1:0]         CfgK,
   input  logic                       IdxVld,
   output logic                       IdxRdy,
   input  logic [IDX_WIDTH-1:0]       IdxDat,
   output logic                       FeaRdVld,
   input  logic                       FeaRdRdy,
   output logic [IDX_WIDTH-1:0]       FeaRdAddr,
   input  logic                       FeaDatVld,
   output logic                       FeaDatRdy,
   output logic [NUM_PCC-1:0]         PccInVld,
   output logic [NUM_PCC-1:0]         PccInLast,
   input  logic [NUM_PCC-1:0]         PccInRdy,
   output logic [$clog2(NUM_PCC)-1:0] PccSel,
   input  logic [NUM_PCC-1:0]         PccOutVld,
   output logic [NUM_PCC-1:0]         PccOutRdy,
   output logic                       OutVld,
   input  logic                       OutRdy,
   output logic [$clog2(NUM_PCC)-1:0] OutSel,
   output logic [IDX_WIDTH-1:0]       OutPnt,
   output logic                       PccRst,
`ifdef POL_SCHED_PERF_EN
   output logic [31:0]                PerfStall,
`endif
   output logic                       Done
);

   localparam int SEL_W = $clog2(NUM_PCC);
   localparam int PTR_W = $clog2(TAG_DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

   state_t               state_q, state_d;
   logic [IDX_WIDTH-1:0] np_q, np_d;
   logic [IDX_WIDTH-1:0] pnt_q, pnt_d;
   logic [IDX_WIDTH-1:0] out_q, out_d;
   logic [K_WIDTH-1:0]   k_q, k_d;
   logic [K_WIDTH-1:0]   nbr_q, nbr_d;
   logic [NUM_PCC-1:0]   busy_q, busy_d;
   logic [NUM_PCC-1:0]   dlv_q, dlv_d;
   logic [SEL_W:0]       tag_mem_q [TAG_DEPTH];
   logic [SEL_W:0]       tag_mem_d [TAG_DEPTH];
   logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;
   logic                 pcc_rst_q, pcc_rst_d;
   logic                 done_q, done_d;

   logic                 fifo_full, fifo_empty;
   logic [SEL_W:0]       head;
   logic [SEL_W-1:0]     head_core, owner, out_sel;
   logic                 head_last, first_nbr, last_nbr, owner_ok, issue_ok;
   logic                 push, pop, out_ok, out_xfer, cfg_acc, run;

   // nbr_q is a down-counter: reloads with K-1 at each point, terminal count 0 marks the last neighbour
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign head       = tag_mem_q[rd_ptr_q[PTR_W-1:0]];
   assign head_core  = head[SEL_W:1];
   assign head_last  = head[0];
   assign owner      = pnt_q[SEL_W-1:0];
   assign first_nbr  = (nbr_q == (k_q - K_WIDTH'(1)));
   assign last_nbr   = (nbr_q == '0);
   // later neighbours of a point already own the core they set busy
   assign owner_ok   = !first_nbr || !busy_q[owner];
   assign issue_ok   = (state_q == ISSUE) && FeaRdRdy && !fifo_full && owner_ok;
   assign run        = (state_q == ISSUE) || (state_q == DRAIN);

   assign IdxRdy     = issue_ok;
   assign FeaRdVld   = issue_ok && IdxVld;
   assign FeaRdAddr  = IdxDat;
   assign push       = FeaRdVld;

   assign FeaDatRdy  = !fifo_empty && PccInRdy[head_core];
   assign pop        = FeaDatVld && FeaDatRdy;
   assign PccSel     = head_core;

   assign out_sel    = out_q[SEL_W-1:0];
   assign out_ok     = run && busy_q[out_sel] && dlv_q[out_sel];
   assign OutVld     = PccOutVld[out_sel] && out_ok;
   assign out_xfer   = OutVld && OutRdy;
   assign OutSel     = out_sel;
   assign OutPnt     = out_q;

   assign CfgRdy     = (state_q == IDLE);
   assign cfg_acc    = CfgVld && CfgRdy;
   assign PccRst     = Rst || pcc_rst_q;
   assign Done       = done_q;

   // per-core steering of the return beat and the result ready
   always_comb begin
      PccInVld  = '0;
      PccInLast = '0;
      PccOutRdy = '0;
      PccInVld[head_core]  = FeaDatVld && !fifo_empty;
      PccInLast[head_core] = head_last;
      PccOutRdy[out_sel]   = OutRdy && out_ok;
   end

   // next-state: counters, busy tracking, tag FIFO and FSM
   always_comb begin
      state_d   = state_q;
      np_d      = np_q;
      k_d       = k_q;
      pnt_d     = pnt_q;
      nbr_d     = nbr_q;
      out_d     = out_q;
      busy_d    = busy_q;
      dlv_d     = dlv_q;
      tag_mem_d = tag_mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      pcc_rst_d = 1'b0;
      done_d    = (state_q == FIN);

      if (push) begin
         tag_mem_d[wr_ptr_q[PTR_W-1:0]] = {owner, last_nbr};
         wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
         if (first_nbr) begin
            busy_d[owner] = 1'b1;
            dlv_d[owner]  = 1'b0;
         end
         if (last_nbr) begin
            nbr_d = k_q - K_WIDTH'(1);
            pnt_d = pnt_q + IDX_WIDTH'(1);
         end else begin
            nbr_d = nbr_q - K_WIDTH'(1);
         end
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
         if (head_last) dlv_d[head_core] = 1'b1;
      end

      if (out_xfer) begin
         busy_d[out_sel] = 1'b0;
         dlv_d[out_sel]  = 1'b0;
         out_d           = out_q + IDX_WIDTH'(1);
      end

      case (state_q)
         IDLE: begin
            if (cfg_acc) begin
               np_d      = CfgNp;
               k_d       = CfgK;
               pnt_d     = '0;
               nbr_d     = CfgK - K_WIDTH'(1);
               out_d     = '0;
               pcc_rst_d = 1'b1;
               state_d   = ((CfgNp == '0) || (CfgK == '0)) ? FIN : ISSUE;
            end
         end
         ISSUE: begin
            if (push && last_nbr && (pnt_q == (np_q - IDX_WIDTH'(1)))) state_d = DRAIN;
         end
         DRAIN: begin
            if ((out_q == np_q) && fifo_empty) state_d = FIN;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state registers with synchronous reset; tag storage needs no reset
   always_ff @(posedge clk) begin
      if (Rst) begin
         state_q   <= IDLE;
         np_q      <= '0;
         k_q       <= '0;
         pnt_q     <= '0;
         nbr_q     <= '0;
         out_q     <= '0;
         busy_q    <= '0;
         dlv_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         pcc_rst_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         np_q      <= np_d;
         k_q       <= k_d;
         pnt_q     <= pnt_d;
         nbr_q     <= nbr_d;
         out_q     <= out_d;
         busy_q    <= busy_d;
         dlv_q     <= dlv_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         pcc_rst_q <= pcc_rst_d;
         done_q    <= done_d;
      end
      tag_mem_q <= tag_mem_d;
   end

`ifdef POL_SCHED_PERF_EN
   logic [31:0] perf_q, perf_d;

   // saturating count of issue cycles stalled with an index waiting
   always_comb begin
      perf_d = perf_q;
      if (cfg_acc) begin
         perf_d = '0;
      end else if ((state_q == ISSUE) && IdxVld && !IdxRdy && (perf_q != '1)) begin
         perf_d = perf_q + 32'd1;
      end
   end

   // stall counter register
   always_ff @(posedge clk) begin
      if (Rst) perf_q <= '0;
      else     perf_q <= perf_d;
   end

   assign PerfStall = perf_q;
`endif

endmodule

// File: tb/tb_pol_sched.sv
// tb_pol_sched: randomized self-checking bench for pol_sched.
// Reference model: request order follows the index stream, beat j belongs to
// point j/K on core (j/K) mod NUM_PCC, results must leave in point order.
module tb_pol_sched;

   localparam int NPCC  = 4;
   localparam int IDX_W = 16;
   localparam int K_W   = 6;
   localparam int TD    = 8;
   localparam int SW    = $clog2(NPCC);

   logic              clk = 1'b0;
   logic              Rst;
   logic              CfgVld;
   logic              CfgRdy;
   logic [IDX_W-1:0]  CfgNp;
   logic [K_W-1:0]    CfgK;
   logic              IdxVld;
   logic              IdxRdy;
   logic [IDX_W-1:0]  IdxDat;
   logic              FeaRdVld;
   logic              FeaRdRdy;
   logic [IDX_W-1:0]  FeaRdAddr;
   logic              FeaDatVld;
   logic              FeaDatRdy;
   logic [NPCC-1:0]   PccInVld;
   logic [NPCC-1:0]   PccInLast;
   logic [NPCC-1:0]   PccInRdy;
   logic [SW-1:0]     PccSel;
   logic [NPCC-1:0]   PccOutVld;
   logic [NPCC-1:0]   PccOutRdy;
   logic              OutVld;
   logic              OutRdy;
   logic [SW-1:0]     OutSel;
   logic [IDX_W-1:0]  OutPnt;
   logic              PccRst;
   logic              Done;
`ifdef POL_SCHED_PERF_EN
   logic [31:0]       PerfStall;
`endif

   int total = 0;
   int bad   = 0;

   logic [IDX_W-1:0] idx_list[$];
   int               mem_q[$];
   bit [NPCC-1:0]    has_res;

   pol_sched #(.NUM_PCC(NPCC), .IDX_WIDTH(IDX_W), .K_WIDTH(K_W), .TAG_DEPTH(TD)) dut (
      .clk(clk), .Rst(Rst),
      .CfgVld(CfgVld), .CfgRdy(CfgRdy), .CfgNp(CfgNp), .CfgK(CfgK),
      .IdxVld(IdxVld), .IdxRdy(IdxRdy), .IdxDat(IdxDat),
      .FeaRdVld(FeaRdVld), .FeaRdRdy(FeaRdRdy), .FeaRdAddr(FeaRdAddr),
      .FeaDatVld(FeaDatVld), .FeaDatRdy(FeaDatRdy),
      .PccInVld(PccInVld), .PccInLast(PccInLast), .PccInRdy(PccInRdy), .PccSel(PccSel),
      .PccOutVld(PccOutVld), .PccOutRdy(PccOutRdy),
      .OutVld(OutVld), .OutRdy(OutRdy), .OutSel(OutSel), .OutPnt(OutPnt),
      .PccRst(PccRst),
`ifdef POL_SCHED_PERF_EN
      .PerfStall(PerfStall),
`endif
      .Done(Done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task set_idle;
      CfgVld    = 1'b0;
      CfgNp     = '0;
      CfgK      = '0;
      IdxVld    = 1'b0;
      IdxDat    = '0;
      FeaRdRdy  = 1'b0;
      FeaDatVld = 1'b0;
      PccInRdy  = '0;
      PccOutVld = '0;
      OutRdy    = 1'b0;
   endtask

   task test_reset;
      set_idle;
      IdxVld = 1'b1; FeaRdRdy = 1'b1; FeaDatVld = 1'b1;
      PccInRdy = '1; PccOutVld = '1; OutRdy = 1'b1;
      Rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #4;
      total++; if (PccRst !== 1'b1) begin bad++; $display("FAIL rst_pccrst got=%b exp=1", PccRst); end
      total++; if (CfgRdy !== 1'b1) begin bad++; $display("FAIL rst_cfgrdy got=%b exp=1", CfgRdy); end
      total++; if (Done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", Done); end
      total++; if (OutVld !== 1'b0) begin bad++; $display("FAIL rst_outvld got=%b exp=0", OutVld); end
      total++; if (FeaRdVld !== 1'b0) begin bad++; $display("FAIL rst_feardvld got=%b exp=0", FeaRdVld); end
      total++; if (PccInVld !== '0) begin bad++; $display("FAIL rst_pccinvld got=%b exp=0", PccInVld); end
      total++; if (PccOutRdy !== '0) begin bad++; $display("FAIL rst_pccoutrdy got=%b exp=0", PccOutRdy); end
      total++; if (IdxRdy !== 1'b0) begin bad++; $display("FAIL rst_idxrdy got=%b exp=0", IdxRdy); end
      total++; if (FeaDatRdy !== 1'b0) begin bad++; $display("FAIL rst_featdatrdy got=%b exp=0", FeaDatRdy); end
      @(posedge clk); #1;
      Rst = 1'b0;
      set_idle;
      @(posedge clk); #1;
      #4;
      total++; if (PccRst !== 1'b0) begin bad++; $display("FAIL rst_pccrst_release got=%b exp=0", PccRst); end
      @(posedge clk); #1;
   endtask

   task run_job(input int np, input int k, input bit rnd, input int hold_out, input int hold_dat);
      int req_cnt, out_cnt, budget, ec, sel, cyc;
      bit el, done_seen;
      logic [NPCC-1:0] exp_vld, exp_ordy;
      idx_list = {};
      mem_q    = {};
      has_res  = '0;
      for (int i = 0; i < np * k; i++) idx_list.push_back(IDX_W'($urandom));
      req_cnt = 0; out_cnt = 0; done_seen = 1'b0; ec = 0; el = 1'b0;
      budget = 300 + np * k * 30 + hold_out + hold_dat;
      set_idle;
      CfgVld = 1'b1; CfgNp = IDX_W'(np); CfgK = K_W'(k);
      #4;
      total++; if (CfgRdy !== 1'b1) begin bad++; $display("FAIL job_cfgrdy got=%b exp=1", CfgRdy); end
      @(posedge clk); #1;
      CfgVld = 1'b0;
      for (cyc = 0; cyc < budget && !done_seen; cyc++) begin
         IdxVld    = (req_cnt < np * k) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
         IdxDat    = IdxVld ? idx_list[req_cnt] : IDX_W'($urandom);
         FeaRdRdy  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         FeaDatVld = (mem_q.size() > 0) && (cyc >= hold_dat) && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
         PccInRdy  = rnd ? NPCC'($urandom) : '1;
         PccOutVld = has_res;
         OutRdy    = (cyc >= hold_out) && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
         #4;
         if (hold_out > 0 && cyc == hold_out - 1) begin
            total++; if (req_cnt != NPCC * k) begin bad++; $display("FAIL hold_out_reqs got=%0d exp=%0d", req_cnt, NPCC * k); end
            total++; if (IdxRdy !== 1'b0) begin bad++; $display("FAIL hold_out_idxrdy got=%b exp=0", IdxRdy); end
            total++; if (out_cnt != 0) begin bad++; $display("FAIL hold_out_outs got=%0d exp=0", out_cnt); end
         end
         if (hold_dat > 0 && cyc == hold_dat - 1) begin
            total++; if (req_cnt != TD) begin bad++; $display("FAIL hold_dat_reqs got=%0d exp=%0d", req_cnt, TD); end
            total++; if (IdxRdy !== 1'b0) begin bad++; $display("FAIL hold_dat_idxrdy got=%b exp=0", IdxRdy); end
         end
         exp_vld = '0;
         if (mem_q.size() > 0) begin
            ec = (mem_q[0] / k) % NPCC;
            el = ((mem_q[0] % k) == k - 1);
            if (FeaDatVld) exp_vld[ec] = 1'b1;
         end
         total++; if (PccInVld !== exp_vld) begin bad++; $display("FAIL pcc_in_vld got=%b exp=%b", PccInVld, exp_vld); end
         total++; if (FeaRdVld !== (IdxVld && IdxRdy)) begin bad++; $display("FAIL fea_rd_vld got=%b exp=%b", FeaRdVld, IdxVld && IdxRdy); end
         if (FeaDatRdy === 1'b1) begin
            total++;
            if (mem_q.size() == 0 || PccInRdy[ec] !== 1'b1) begin
               bad++; $display("FAIL fea_dat_rdy got=1 pending=%0d core_rdy=%b", mem_q.size(), PccInRdy);
            end
         end
         if (Done === 1'b1) begin
            done_seen = 1'b1;
            total++; if (out_cnt != np) begin bad++; $display("FAIL done_outs got=%0d exp=%0d", out_cnt, np); end
            total++; if (req_cnt != np * k) begin bad++; $display("FAIL done_reqs got=%0d exp=%0d", req_cnt, np * k); end
         end
         if (FeaDatVld && FeaDatRdy && mem_q.size() > 0) begin
            void'(mem_q.pop_front());
            total++; if (PccSel !== SW'(ec)) begin bad++; $display("FAIL pcc_sel got=%0d exp=%0d", PccSel, ec); end
            total++; if (PccInLast[ec] !== el) begin bad++; $display("FAIL pcc_in_last got=%b exp=%b", PccInLast[ec], el); end
            if (el) has_res[ec] = 1'b1;
         end
         if (IdxVld && IdxRdy) begin
            total++; if (FeaRdAddr !== idx_list[req_cnt]) begin bad++; $display("FAIL fea_rd_addr got=%h exp=%h", FeaRdAddr, idx_list[req_cnt]); end
            if (req_cnt % k == 0) begin
               total++;
               if (req_cnt / k >= out_cnt + NPCC) begin
                  bad++; $display("FAIL core_free point=%0d results_out=%0d", req_cnt / k, out_cnt);
               end
            end
            mem_q.push_back(req_cnt);
            req_cnt++;
         end
         if (OutVld && OutRdy) begin
            sel = out_cnt % NPCC;
            exp_ordy = '0; exp_ordy[sel] = 1'b1;
            total++; if (OutPnt !== IDX_W'(out_cnt)) begin bad++; $display("FAIL out_pnt got=%0d exp=%0d", OutPnt, out_cnt); end
            total++; if (OutSel !== SW'(sel)) begin bad++; $display("FAIL out_sel got=%0d exp=%0d", OutSel, sel); end
            total++; if (PccOutRdy !== exp_ordy) begin bad++; $display("FAIL pcc_out_rdy got=%b exp=%b", PccOutRdy, exp_ordy); end
            total++; if (has_res[sel] !== 1'b1) begin bad++; $display("FAIL out_early core=%0d has no result", sel); end
            has_res[sel] = 1'b0;
            out_cnt++;
         end
         @(posedge clk); #1;
      end
      total++; if (!done_seen) begin bad++; $display("FAIL job_timeout got=no_done exp=done np=%0d k=%0d", np, k); end
      set_idle;
      #4;
      total++; if (Done !== 1'b0) begin bad++; $display("FAIL done_pulse got=%b exp=0", Done); end
      total++; if (CfgRdy !== 1'b1) begin bad++; $display("FAIL post_job_cfgrdy got=%b exp=1", CfgRdy); end
      @(posedge clk); #1;
   endtask

   task test_basic;
      run_job(3, 2, 1'b0, 0, 0);
   endtask

   task test_zero;
      int np_v[2];
      int k_v[2];
      np_v[0] = 0; k_v[0] = 3;
      np_v[1] = 3; k_v[1] = 0;
      for (int t = 0; t < 2; t++) begin
         set_idle;
         IdxVld = 1'b1; FeaRdRdy = 1'b1;
         CfgVld = 1'b1; CfgNp = IDX_W'(np_v[t]); CfgK = K_W'(k_v[t]);
         #4;
         total++; if (CfgRdy !== 1'b1) begin bad++; $display("FAIL zero_cfgrdy got=%b exp=1", CfgRdy); end
         @(posedge clk); #1;
         CfgVld = 1'b0;
         #4;
         total++; if (Done !== 1'b0) begin bad++; $display("FAIL zero_done_early got=%b exp=0", Done); end
         total++; if (PccRst !== 1'b1) begin bad++; $display("FAIL zero_pccrst got=%b exp=1", PccRst); end
         total++; if (FeaRdVld !== 1'b0) begin bad++; $display("FAIL zero_feardvld got=%b exp=0", FeaRdVld); end
         @(posedge clk); #1;
         #4;
         total++; if (Done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b exp=1", Done); end
         total++; if (FeaRdVld !== 1'b0) begin bad++; $display("FAIL zero_feardvld2 got=%b exp=0", FeaRdVld); end
         @(posedge clk); #1;
         #4;
         total++; if (Done !== 1'b0) begin bad++; $display("FAIL zero_done_late got=%b exp=0", Done); end
         @(posedge clk); #1;
      end
      set_idle;
   endtask

   task test_backpressure;
      run_job(6, 2, 1'b0, 40, 0);
   endtask

   task test_fifo_full;
      run_job(1, 16, 1'b0, 0, 30);
   endtask

   task test_random;
      for (int j = 0; j < 6; j++) run_job($urandom_range(1, 11), $urandom_range(1, 5), 1'b1, 0, 0);
   endtask

   task test_back_to_back;
      run_job(5, 3, 1'b1, 0, 0);
      run_job(2, 1, 1'b0, 0, 0);
   endtask

   task test_reset_mid;
      int req;
      set_idle;
      CfgVld = 1'b1; CfgNp = IDX_W'(1); CfgK = K_W'(3);
      @(posedge clk); #1;
      CfgVld = 1'b0; FeaRdRdy = 1'b1; PccInRdy = '1;
      req = 0;
      for (int i = 0; i < 20 && req < 3; i++) begin
         IdxVld = 1'b1; IdxDat = IDX_W'(i + 100);
         #4;
         if (IdxVld && IdxRdy) req++;
         @(posedge clk); #1;
      end
      IdxVld = 1'b0;
      #4;
      total++; if (req != 3) begin bad++; $display("FAIL mid_reqs got=%0d exp=3", req); end
      total++; if (FeaDatRdy !== 1'b1) begin bad++; $display("FAIL mid_pending got=%b exp=1", FeaDatRdy); end
      total++; if (CfgRdy !== 1'b0) begin bad++; $display("FAIL mid_busy_cfgrdy got=%b exp=0", CfgRdy); end
      @(posedge clk); #1;
      Rst = 1'b1;
      #4;
      total++; if (PccRst !== 1'b1) begin bad++; $display("FAIL mid_pccrst got=%b exp=1", PccRst); end
      @(posedge clk); #1;
      Rst = 1'b0; FeaDatVld = 1'b1;
      #4;
      total++; if (CfgRdy !== 1'b1) begin bad++; $display("FAIL mid_cfgrdy got=%b exp=1", CfgRdy); end
      total++; if (FeaDatRdy !== 1'b0) begin bad++; $display("FAIL mid_fifo_empty got=%b exp=0", FeaDatRdy); end
      total++; if (PccInVld !== '0) begin bad++; $display("FAIL mid_pccinvld got=%b exp=0", PccInVld); end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         #4;
         total++; if (Done !== 1'b0) begin bad++; $display("FAIL mid_no_done got=%b exp=0", Done); end
      end
      @(posedge clk); #1;
      set_idle;
      run_job(5, 3, 1'b1, 0, 0);
   endtask

`ifdef POL_SCHED_PERF_EN
   task test_perf;
      set_idle;
      CfgVld = 1'b1; CfgNp = IDX_W'(1); CfgK = K_W'(8);
      IdxVld = 1'b1; IdxDat = IDX_W'(7);
      @(posedge clk); #1;
      CfgVld = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      FeaRdRdy = 1'b1;
      #4;
      total++; if (PerfStall !== 32'd5) begin bad++; $display("FAIL perf_stall got=%0d exp=5", PerfStall); end
      @(posedge clk); #1;
      Rst = 1'b1;
      @(posedge clk); #1;
      Rst = 1'b0;
      set_idle;
      #4;
      total++; if (PerfStall !== 32'd0) begin bad++; $display("FAIL perf_clear got=%0d exp=0", PerfStall); end
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      Rst = 1'b1;
      set_idle;
      test_reset;
      test_basic;
      test_zero;
      test_backpressure;
      test_fifo_full;
      test_random;
      test_back_to_back;
      test_reset_mid;
`ifdef POL_SCHED_PERF_EN
      test_perf;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
